prng_sequencer: RTL and testbench

Controller and state register for the pseudo-random generator. It loads a seed, then advances a Fibonacci LFSR either by single-step commands or free-running at a programmable tick rate. It flags each new output value and measures the sequence period against the loaded seed. It sits between the board-level controls (switches and buttons) and the LED/output logic, and replaces the fixed clock-division approach with a per-cycle enable.

---
 rtl/prng_sequencer.sv | 122 ++++++++++++
 tb/tb_prng_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_sequencer.sv
// Seed-loadable Fibonacci LFSR with single-step and free-running modes,
// new-value flagging and period measurement against the loaded seed.
module prng_sequencer #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter int              DIV_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div_max,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             period_done,
  output logic [WIDTH-1:0] period,
  output logic             err_zero,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  logic [WIDTH-1:0] seed_lat;
  logic [WIDTH-1:0] step_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             fb;
  logic [WIDTH-1:0] q_next;
  logic             adv;

  always_comb begin
    fb     = ^(q & TAPS);
    q_next = {q[WIDTH-2:0], fb};
  end

  // One advance per cycle at most: a HOLD step request or a RUN divider match,
  // both only when load is not pre-empting them.
  always_comb begin
    adv = 1'b0;
    if (!load) begin
      if (state == S_HOLD)
        adv = !run && step;
      else if (state == S_RUN)
        adv = run && (div_cnt == div_max);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      q           <= '0;
      seed_lat    <= '0;
      step_cnt    <= '0;
      div_cnt     <= '0;
      valid       <= 1'b0;
      period_done <= 1'b0;
      period      <= '0;
      err_zero    <= 1'b0;
    end else begin
      valid       <= 1'b0;
      period_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (load) state <= S_LOAD;
        end
        S_LOAD: begin
          if (seed == '0) begin
            q        <= WIDTH'(1);
            seed_lat <= WIDTH'(1);
            err_zero <= 1'b1;
          end else begin
            q        <= seed;
            seed_lat <= seed;
            err_zero <= 1'b0;
          end
          step_cnt <= '0;
          div_cnt  <= '0;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (load) begin
            state <= S_LOAD;
          end else if (run) begin
            state   <= S_RUN;
            div_cnt <= '0;
          end
        end
        S_RUN: begin
          if (load) begin
            state <= S_LOAD;
          end else if (!run) begin
            state   <= S_HOLD;
            div_cnt <= '0;
          end else if (div_cnt == div_max) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        q     <= q_next;
        valid <= 1'b1;
        if (q_next == seed_lat) begin
          period      <= step_cnt + WIDTH'(1);
          step_cnt    <= '0;
          period_done <= 1'b1;
        end else begin
          step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prng_sequencer.sv
// Self-checking bench for prng_sequencer: scenario tasks compared against
// a sequence-level LFSR reference model.
module tb_prng_sequencer;

  localparam int W     = 8;
  localparam int DIV_W = 20;
  localparam logic [W-1:0] TAPS = 8'hB8;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     seed;
  logic             load;
  logic             run;
  logic             step;
  logic [DIV_W-1:0] div_max;
  logic [W-1:0]     q;
  logic             valid;
  logic             period_done;
  logic [W-1:0]     period;
  logic             err_zero;
  logic [1:0]       state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_period = '0;

  prng_sequencer #(.WIDTH(W), .TAPS(TAPS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .run(run), .step(step),
    .div_max(div_max), .q(q), .valid(valid), .period_done(period_done),
    .period(period), .err_zero(err_zero), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: next value counts the ones under the tap mask and appends parity.
  function automatic logic [W-1:0] lfsr_ref(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++)
      if (TAPS[i] && v[i]) ones++;
    return W'((int'(v) * 2) % 256 + (ones % 2));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] s);
    seed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 0; run = 0; step = 0; seed = '0; div_max = '0;
    #3;
    n_checks++;
    if ({q, valid, period_done, period, err_zero, state} !== '0)
      $display("FAIL reset_outputs: q=%h v=%b pd=%b per=%h ez=%b st=%b, required all zero",
               q, valid, period_done, period, err_zero, state);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    seed = 8'h01;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (state !== 2'b01 || q !== 8'h00)
      $display("FAIL load_first_edge: state=%b q=%h, required 01/00", state, q);
    else n_pass++;
    tick();
    n_checks++;
    if (q !== 8'h01 || state !== 2'b11 || err_zero !== 1'b0 || valid !== 1'b0)
      $display("FAIL load_second_edge: q=%h st=%b ez=%b v=%b, required 01/11/0/0",
               q, state, err_zero, valid);
    else n_pass++;
  endtask

  task automatic single_step_check(input logic [W-1:0] s, input logic [W-1:0] want);
    do_load(s);
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++;
    if (q !== want || valid !== 1'b1)
      $display("FAIL single_step_%h: q=%h v=%b, required %h/1", s, q, valid, want);
    else n_pass++;
    tick();
    n_checks++;
    if (q !== want || valid !== 1'b0 || state !== 2'b11)
      $display("FAIL single_step_after_%h: q=%h v=%b st=%b, required %h/0/11",
               s, q, valid, state, want);
    else n_pass++;
  endtask

  task automatic test_step;
    logic [W-1:0] s;
    logic [W-1:0] eq;
    single_step_check(8'h01, 8'h02);
    single_step_check(8'h80, 8'h01);
    s = W'($urandom_range(1, 255));
    do_load(s);
    eq = s;
    for (int i = 0; i < 30; i++) begin
      step = 1'($urandom_range(0, 1));
      tick();
      if (step) eq = lfsr_ref(eq);
      n_checks++;
      if (q !== eq || valid !== step)
        $display("FAIL random_step_%0d: q=%h v=%b, required %h/%b", i, q, valid, eq, step);
      else n_pass++;
    end
    step = 1'b0;
  endtask

  task automatic test_period;
    logic [W-1:0] eq;
    int cnt;
    logic epd;
    do_load(8'h01);
    div_max = '0;
    run = 1'b1;
    tick();
    eq = 8'h01;
    cnt = 0;
    for (int i = 1; i <= 510; i++) begin
      tick();
      eq = lfsr_ref(eq);
      cnt++;
      epd = (eq == 8'h01);
      if (epd) begin
        exp_period = W'(cnt);
        cnt = 0;
      end
      n_checks++;
      if (valid !== 1'b1 || q !== eq || period_done !== epd || period !== exp_period)
        $display("FAIL period_run_%0d: v=%b q=%h pd=%b per=%h, required 1/%h/%b/%h",
                 i, valid, q, period_done, period, eq, epd, exp_period);
      else n_pass++;
      if (i == 255 || i == 510) begin
        n_checks++;
        if (period_done !== 1'b1 || period !== 8'hFF || q !== 8'h01)
          $display("FAIL period_value_%0d: pd=%b per=%h q=%h, required 1/ff/01",
                   i, period_done, period, q);
        else n_pass++;
      end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic free_run(input int d, input int k);
    logic [W-1:0] s;
    logic [W-1:0] eq;
    logic ev;
    int nv;
    s = W'($urandom_range(1, 255));
    do_load(s);
    div_max = DIV_W'(d);
    run = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'b10 || valid !== 1'b0)
      $display("FAIL run_entry_d%0d: st=%b v=%b, required 10/0", d, state, valid);
    else n_pass++;
    eq = s;
    nv = 0;
    // Run for k full periods minus one cycle, so the drop lands on a would-be step.
    for (int c = 1; c <= k * (d + 1) - 1; c++) begin
      tick();
      ev = (c % (d + 1) == 0);
      if (ev) begin
        eq = lfsr_ref(eq);
        nv++;
      end
      n_checks++;
      if (valid !== ev || q !== eq || period_done !== (ev && eq == s))
        $display("FAIL free_run_d%0d_c%0d: v=%b q=%h pd=%b, required %b/%h/%b",
                 d, c, valid, q, period_done, ev, eq, (ev && eq == s));
      else n_pass++;
    end
    n_checks++;
    if (nv != k - 1)
      $display("FAIL free_run_count_d%0d: pulses=%0d, required %0d", d, nv, k - 1);
    else n_pass++;
    run = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'b11 || valid !== 1'b0 || q !== eq)
      $display("FAIL run_drop_d%0d: st=%b v=%b q=%h, required 11/0/%h", d, state, valid, q, eq);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (valid !== 1'b0 || q !== eq)
        $display("FAIL hold_quiet_d%0d_%0d: v=%b q=%h, required 0/%h", d, c, valid, q, eq);
      else n_pass++;
    end
  endtask

  task automatic test_free_run;
    free_run(3, 6);
    free_run($urandom_range(0, 6), $urandom_range(3, 8));
    free_run($urandom_range(1, 4), $urandom_range(3, 8));
  endtask

  task automatic test_zero_seed;
    do_load(8'h00);
    n_checks++;
    if (q !== 8'h01 || err_zero !== 1'b1 || state !== 2'b11)
      $display("FAIL zero_seed: q=%h ez=%b st=%b, required 01/1/11", q, err_zero, state);
    else n_pass++;
    do_load(8'h5A);
    n_checks++;
    if (q !== 8'h5A || err_zero !== 1'b0)
      $display("FAIL reseed_5a: q=%h ez=%b, required 5a/0", q, err_zero);
    else n_pass++;
  endtask

  task automatic test_load_priority;
    logic [W-1:0] s;
    do_load(8'h33);
    s = W'($urandom_range(1, 255));
    seed = s;
    load = 1'b1;
    step = 1'b1;
    tick();
    load = 1'b0;
    step = 1'b0;
    n_checks++;
    if (state !== 2'b01 || valid !== 1'b0 || q !== 8'h33)
      $display("FAIL load_vs_step: st=%b v=%b q=%h, required 01/0/33", state, valid, q);
    else n_pass++;
    tick();
    n_checks++;
    if (q !== s || state !== 2'b11 || valid !== 1'b0)
      $display("FAIL load_vs_step_after: q=%h st=%b v=%b, required %h/11/0", q, state, valid, s);
    else n_pass++;
  endtask

  task automatic test_rst_mid_run;
    do_load(8'h01);
    div_max = '0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    exp_period = '0;
    n_checks++;
    if ({q, valid, period_done, period, err_zero, state} !== '0)
      $display("FAIL async_reset: q=%h v=%b pd=%b per=%h ez=%b st=%b, required all zero",
               q, valid, period_done, period, err_zero, state);
    else n_pass++;
    #3;
    rst = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (state !== 2'b00 || q !== 8'h00 || valid !== 1'b0)
        $display("FAIL idle_ignores_%0d: st=%b q=%h v=%b, required 00/00/0", i, state, q, valid);
      else n_pass++;
    end
    step = 1'b0;
    run = 1'b0;
    do_load(8'hA5);
    n_checks++;
    if (q !== 8'hA5 || state !== 2'b11)
      $display("FAIL reload_after_reset: q=%h st=%b, required a5/11", q, state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_period();
    test_free_run();
    test_zero_seed();
    test_load_priority();
    test_rst_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
